// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid device port among NrHosts bus hosts.
// An ordering FIFO of host indices routes in-order responses back to their issuers.
module bus_host_arbiter #(
    parameter int NrHosts        = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [NrHosts-1:0]                       host_req_i,
    output logic [NrHosts-1:0]                       host_gnt_o,
    input  logic [NrHosts-1:0][AddressWidth-1:0]     host_addr_i,
    input  logic [NrHosts-1:0]                       host_we_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]      host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]        host_wdata_i,
    output logic [NrHosts-1:0]                       host_rvalid_o,
    output logic [DataWidth-1:0]                     host_rdata_o,
    output logic                                     host_err_o,
    output logic                                     dev_req_o,
    input  logic                                     dev_gnt_i,
    output logic [AddressWidth-1:0]                  dev_addr_o,
    output logic                                     dev_we_o,
    output logic [DataWidth/8-1:0]                   dev_be_o,
    output logic [DataWidth-1:0]                     dev_wdata_o,
    input  logic                                     dev_rvalid_i,
    input  logic [DataWidth-1:0]                     dev_rdata_i,
    input  logic                                     dev_err_i,
    output logic                                     busy_o,
    output logic                                     protocol_err_o
);

    localparam int PtrW  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int FifoW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW  = $clog2(MaxOutstanding + 1);
    localparam logic [NrHosts-1:0] OneHot = {{(NrHosts-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_GNT = 1'b1
    } state_e;

    state_e            state_r, state_n_s;
    logic [PtrW-1:0]   rr_ptr_r, rr_ptr_n_s;
    logic [PtrW-1:0]   lock_r, lock_n_s;
    logic [CntW-1:0]   cnt_r;
    logic [FifoW-1:0]  wr_ptr_r, rd_ptr_r;
    logic [PtrW-1:0]   fifo_r [MaxOutstanding];

    logic [PtrW-1:0]   scan_idx_s;
    logic [PtrW-1:0]   winner_s;
    logic [PtrW-1:0]   next_rr_s;
    logic [PtrW-1:0]   head_s;
    logic              full_s;
    logic              empty_s;
    logic              dev_req_s;
    logic              hs_s;
    logic              pop_s;

    function automatic logic [PtrW-1:0] wrap_idx(input logic [PtrW-1:0] base, input int off);
        return PtrW'((int'(base) + off) % NrHosts);
    endfunction

    function automatic logic [FifoW-1:0] fifo_inc(input logic [FifoW-1:0] ptr);
        return (ptr == FifoW'(MaxOutstanding - 1)) ? {FifoW{1'b0}} : ptr + FifoW'(1);
    endfunction

    // Round-robin scan from rr_ptr; descending loop so the nearest requester is assigned last.
    always_comb begin
        scan_idx_s = rr_ptr_r;
        for (int i = NrHosts - 1; i >= 0; i--) begin
            scan_idx_s = host_req_i[wrap_idx(rr_ptr_r, i)] ? wrap_idx(rr_ptr_r, i) : scan_idx_s;
        end
    end

    // Winner selection, handshake and response qualification.
    always_comb begin
        case (state_r)
            IDLE:     winner_s = scan_idx_s;
            WAIT_GNT: winner_s = lock_r;
            default:  winner_s = scan_idx_s;
        endcase
        empty_s   = (cnt_r == {CntW{1'b0}});
        full_s    = (cnt_r == CntW'(MaxOutstanding));
        dev_req_s = !rst_i && host_req_i[winner_s] && !full_s;
        hs_s      = dev_req_s && dev_gnt_i;
        pop_s     = !rst_i && dev_rvalid_i && !empty_s;
        head_s    = fifo_r[rd_ptr_r];
        next_rr_s = wrap_idx(winner_s, 1);
    end

    // Device-side and host-side outputs; everything reads zero while in reset.
    always_comb begin
        dev_req_o      = dev_req_s;
        dev_addr_o     = dev_req_s ? host_addr_i[winner_s]  : {AddressWidth{1'b0}};
        dev_we_o       = dev_req_s ? host_we_i[winner_s]    : 1'b0;
        dev_be_o       = dev_req_s ? host_be_i[winner_s]    : {(DataWidth/8){1'b0}};
        dev_wdata_o    = dev_req_s ? host_wdata_i[winner_s] : {DataWidth{1'b0}};
        host_gnt_o     = hs_s  ? (OneHot << winner_s) : {NrHosts{1'b0}};
        host_rvalid_o  = pop_s ? (OneHot << head_s)   : {NrHosts{1'b0}};
        host_rdata_o   = pop_s ? dev_rdata_i          : {DataWidth{1'b0}};
        host_err_o     = pop_s && dev_err_i;
        busy_o         = !rst_i && !empty_s;
        protocol_err_o = !rst_i &&
                         (((state_r == WAIT_GNT) && !host_req_i[lock_r]) ||
                          (dev_rvalid_i && empty_s));
    end

    // Next-state logic: lock on a stalled request, release on handshake or withdrawn request.
    always_comb begin
        state_n_s  = state_r;
        lock_n_s   = lock_r;
        rr_ptr_n_s = rr_ptr_r;
        case (state_r)
            IDLE: begin
                if (hs_s) begin
                    rr_ptr_n_s = next_rr_s;
                end else if (dev_req_s) begin
                    state_n_s = WAIT_GNT;
                    lock_n_s  = winner_s;
                end else begin
                    state_n_s = IDLE;
                end
            end
            WAIT_GNT: begin
                if (hs_s) begin
                    state_n_s  = IDLE;
                    rr_ptr_n_s = next_rr_s;
                end else if (!host_req_i[lock_r]) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = WAIT_GNT;
                end
            end
            default: state_n_s = IDLE;
        endcase
    end

    // Control state, pointers and outstanding count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= IDLE;
            rr_ptr_r <= {PtrW{1'b0}};
            lock_r   <= {PtrW{1'b0}};
            cnt_r    <= {CntW{1'b0}};
            wr_ptr_r <= {FifoW{1'b0}};
            rd_ptr_r <= {FifoW{1'b0}};
        end else begin
            state_r  <= state_n_s;
            rr_ptr_r <= rr_ptr_n_s;
            lock_r   <= lock_n_s;
            if (hs_s) begin
                wr_ptr_r <= fifo_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= fifo_inc(rd_ptr_r);
            end
            case ({hs_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CntW'(1);
                2'b01:   cnt_r <= cnt_r - CntW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Ordering FIFO payload; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk_i) begin
        if (!rst_i && hs_s) begin
            fifo_r[wr_ptr_r] <= winner_s;
        end
    end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Bench for bus_host_arbiter: directed scenarios with literal expectations, then random traffic,
// all compared every cycle against a queue-based reference model.
module tb_bus_host_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N-1:0]             host_req;
    logic [N-1:0]             host_gnt;
    logic [N-1:0][AW-1:0]     host_addr;
    logic [N-1:0]             host_we;
    logic [N-1:0][DW/8-1:0]   host_be;
    logic [N-1:0][DW-1:0]     host_wdata;
    logic [N-1:0]             host_rvalid;
    logic [DW-1:0]            host_rdata;
    logic                     host_err;
    logic                     dev_req;
    logic                     dev_gnt;
    logic [AW-1:0]            dev_addr;
    logic                     dev_we;
    logic [DW/8-1:0]          dev_be;
    logic [DW-1:0]            dev_wdata;
    logic                     dev_rvalid;
    logic [DW-1:0]            dev_rdata;
    logic                     dev_err;
    logic                     busy;
    logic                     protocol_err;

    bus_host_arbiter #(
        .NrHosts(N), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
        .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
        .dev_req_o(dev_req), .dev_gnt_i(dev_gnt), .dev_addr_o(dev_addr), .dev_we_o(dev_we),
        .dev_be_o(dev_be), .dev_wdata_o(dev_wdata), .dev_rvalid_i(dev_rvalid),
        .dev_rdata_i(dev_rdata), .dev_err_i(dev_err), .busy_o(busy),
        .protocol_err_o(protocol_err)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding host order, round-robin start, locked host (-1 = none).
    int q[$];
    int rr = 0;
    int lock = -1;
    int e_winner;
    logic e_req, e_hs, e_pop;
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic eval();
        int c;
        #1;
        e_winner = -1;
        if (lock >= 0) e_winner = lock;
        else begin
            for (int k = N - 1; k >= 0; k--) begin
                c = (rr + k) % N;
                if (host_req[c]) e_winner = c;
            end
        end
        e_req = !rst && (e_winner >= 0) && host_req[e_winner] && (q.size() < MO);
        e_hs  = e_req && dev_gnt;
        e_pop = !rst && dev_rvalid && (q.size() > 0);
        chk("dev_req",   dev_req,   e_req);
        chk("host_gnt",  host_gnt,  e_hs ? (64'd1 << e_winner) : 64'd0);
        chk("dev_addr",  dev_addr,  e_req ? host_addr[e_winner]  : 64'd0);
        chk("dev_we",    dev_we,    e_req ? host_we[e_winner]    : 64'd0);
        chk("dev_be",    dev_be,    e_req ? host_be[e_winner]    : 64'd0);
        chk("dev_wdata", dev_wdata, e_req ? host_wdata[e_winner] : 64'd0);
        chk("host_rvalid", host_rvalid, e_pop ? (64'd1 << q[0]) : 64'd0);
        chk("host_rdata",  host_rdata,  e_pop ? dev_rdata : 64'd0);
        chk("host_err",    host_err,    e_pop && dev_err);
        chk("busy",        busy,        !rst && (q.size() != 0));
        chk("protocol_err", protocol_err,
            !rst && (((lock >= 0) && !host_req[lock]) || (dev_rvalid && (q.size() == 0))));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            q.delete();
            rr   = 0;
            lock = -1;
        end else begin
            if (e_pop) void'(q.pop_front());
            if (e_hs) begin
                q.push_back(e_winner);
                rr   = (e_winner + 1) % N;
                lock = -1;
            end else if (lock >= 0 && !host_req[lock]) begin
                lock = -1;
            end else if (lock < 0 && e_req) begin
                lock = e_winner;
            end
        end
        #1;
    endtask

    task automatic drive(input logic r, input logic [N-1:0] req, input logic g,
                         input logic rv, input logic er, input logic [DW-1:0] rd);
        rst        = r;
        host_req   = req;
        dev_gnt    = g;
        dev_rvalid = rv;
        dev_err    = er;
        dev_rdata  = rd;
        eval();
    endtask

    initial begin
        host_addr[0]  = 32'h1000_0000;
        host_addr[1]  = 32'h2000_0004;
        host_we       = 2'b10;
        host_be[0]    = 4'hF;
        host_be[1]    = 4'h3;
        host_wdata[0] = 32'hCAFE_0000;
        host_wdata[1] = 32'hCAFE_0001;

        // Reset with activity on every input: all outputs must stay 0.
        drive(1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        chk("rst_gnt", host_gnt, 2'b00);
        chk("rst_rvalid", host_rvalid, 2'b00);
        chk("rst_dev_req", dev_req, 1'b0);
        tick();
        drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();

        // Alternating grants, responses one cycle later to the matching host.
        drive(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("s1_gnt_a", host_gnt, 2'b01);
        tick();
        drive(1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 32'hA0);
        chk("s1_gnt_b", host_gnt, 2'b10);
        chk("s1_rv_a", host_rvalid, 2'b01);
        chk("s1_rdata", host_rdata, 32'hA0);
        tick();
        drive(1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 32'hA1);
        chk("s1_gnt_c", host_gnt, 2'b01);
        chk("s1_rv_b", host_rvalid, 2'b10);
        tick();
        drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 32'hA2);
        chk("s1_rv_c", host_rvalid, 2'b01);
        tick();

        // Response with nothing outstanding.
        drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("s5_rv", host_rvalid, 2'b00);
        chk("s5_perr", protocol_err, 1'b1);
        tick();
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("s5_perr_clear", protocol_err, 1'b0);
        tick();

        // Fill to MaxOutstanding, then one response frees a slot for the next cycle.
        drive(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("s3_gnt_a", host_gnt, 2'b10);
        tick();
        drive(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("s3_gnt_b", host_gnt, 2'b01);
        tick();
        drive(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("s3_full_req", dev_req, 1'b0);
        chk("s3_busy", busy, 1'b1);
        tick();
        drive(1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("s3_no_bypass", dev_req, 1'b0);
        chk("s3_rv", host_rvalid, 2'b10);
        tick();
        drive(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("s3_regrant", host_gnt, 2'b10);
        tick();

        // Simultaneous push and pop at one outstanding, with an error response.
        drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("s4_drain", host_rvalid, 2'b01);
        tick();
        drive(1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 32'hBEEF);
        chk("s4_gnt", host_gnt, 2'b01);
        chk("s4_rv_older", host_rvalid, 2'b10);
        chk("s4_err", host_err, 1'b1);
        tick();
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("s4_busy", busy, 1'b1);
        tick();
        drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("s4_rv_last", host_rvalid, 2'b01);
        tick();

        // Stalled grant keeps the locked host even when another host requests.
        drive(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("s2_addr_a", dev_addr, 32'h2000_0004);
        tick();
        drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("s2_addr_b", dev_addr, 32'h2000_0004);
        tick();
        drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("s2_addr_c", dev_addr, 32'h2000_0004);
        tick();
        drive(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("s2_gnt_h1", host_gnt, 2'b10);
        tick();
        drive(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("s2_gnt_h0", host_gnt, 2'b01);
        tick();

        // Reset with two outstanding; a late response then counts as unexpected.
        drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("s6_rst_busy", busy, 1'b0);
        tick();
        drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("s6_late_rv", host_rvalid, 2'b00);
        chk("s6_late_perr", protocol_err, 1'b1);
        chk("s6_busy", busy, 1'b0);
        tick();
        drive(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("s6_rr_zero", host_gnt, 2'b01);
        tick();

        // Locked host withdraws its request before the grant.
        drive(1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("drop_perr", protocol_err, 1'b1);
        chk("drop_req", dev_req, 1'b0);
        tick();
        drive(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("drop_next", host_gnt, 2'b01);
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            for (int h = 0; h < N; h++) begin
                host_addr[h]  = $urandom;
                host_wdata[h] = $urandom;
                host_be[h]    = 4'($urandom_range(0, 15));
                host_we[h]    = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 99) < 25) host_req[h] = ~host_req[h];
            end
            drive(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0, host_req,
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)), $urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
